// File: rtl/prewish5k_pkg.sv
// Shared constants and types for the prewish5k mask strobe path.
// The controller and the mask responder both import this package.
package prewish5k_pkg;

   localparam int MASK_W = 8;
   localparam int IDX_W  = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Bit index that closes a pattern, and the index a new pattern starts at (MSB).
   localparam logic [IDX_W-1:0] IDX_LAST  = '0;
   localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(MASK_W - 1);

   function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] idx);
      return (idx == IDX_LAST) ? IDX_FIRST : idx - IDX_W'(1);
   endfunction

endpackage

// File: rtl/prewish5k_tick_gen.sv
// Free-running prescaler that emits a one-cycle tick every 2^MASK_CLK_BITS clocks
// while enabled; the count is parked at zero whenever run is low.
module prewish5k_tick_gen #(
   parameter int MASK_CLK_BITS = 19
) (
   input  logic i_clk,
   input  logic RST_I,
   input  logic run,
   output logic tick
);

   logic [MASK_CLK_BITS-1:0] r_presc;

   always_ff @(posedge i_clk) begin
      if (!RST_I || !run) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + MASK_CLK_BITS'(1);
      end
   end

   assign tick = run && (&r_presc);

endmodule

// File: rtl/prewish5k_mask_responder.sv
// Mask strobe target: accepts blink masks over STB/ACK, buffers one pending mask
// and plays the active mask MSB-first on the LED, swapping only at pattern boundaries.
module prewish5k_mask_responder
   import prewish5k_pkg::*;
#(
   parameter int MASK_CLK_BITS = 19,
   parameter int MASK_W        = prewish5k_pkg::MASK_W
) (
   input  logic              i_clk,
   input  logic              RST_I,
   input  logic              STB_I,
   input  logic [MASK_W-1:0] DAT_I,
   output logic              ACK_O,
   output logic              BUSY_O,
   output logic              o_led,
   output logic [IDX_W-1:0]  o_bitidx
);

   state_t            r_state;
   logic [MASK_W-1:0] r_active;
   logic [MASK_W-1:0] r_pending;
   logic              r_pend_v;
   logic [IDX_W-1:0]  r_idx;
   logic              r_ack;
   logic              r_led;

   logic              w_run;
   logic              w_tick;
   logic              w_boundary;
   logic              w_slot_free;
   logic              w_accept;
   logic [IDX_W-1:0]  w_idx_nxt;
   logic [MASK_W-1:0] w_active_nxt;

   assign w_run = (r_state == ST_RUN);

   prewish5k_tick_gen #(
      .MASK_CLK_BITS(MASK_CLK_BITS)
   ) u_tick_gen (
      .i_clk (i_clk),
      .RST_I (RST_I),
      .run   (w_run),
      .tick  (w_tick)
   );

   assign w_boundary = w_tick && (r_idx == IDX_LAST);

   // A full buffer still has room when the boundary drains it in this same cycle.
   assign w_slot_free = !w_run || !r_pend_v || w_boundary;
   assign w_accept    = STB_I && !r_ack && w_slot_free;

   assign w_idx_nxt    = w_tick ? idx_step(r_idx) : r_idx;
   assign w_active_nxt = (w_boundary && r_pend_v) ? r_pending : r_active;

   always_ff @(posedge i_clk) begin
      if (!RST_I) begin
         r_state   <= ST_IDLE;
         r_active  <= '0;
         r_pending <= '0;
         r_pend_v  <= 1'b0;
         r_idx     <= '0;
         r_ack     <= 1'b0;
         r_led     <= 1'b0;
      end else begin
         r_ack <= w_accept;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state  <= ST_RUN;
                  r_active <= DAT_I;
                  r_idx    <= IDX_FIRST;
                  r_led    <= DAT_I[IDX_FIRST];
               end
            end
            ST_RUN: begin
               r_idx    <= w_idx_nxt;
               r_active <= w_active_nxt;
               // LED is registered from the next-cycle mask/index so it always mirrors active[idx].
               r_led    <= w_active_nxt[w_idx_nxt];
               if (w_accept) begin
                  r_pending <= DAT_I;
                  r_pend_v  <= 1'b1;
               end else if (w_boundary) begin
                  r_pend_v  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ACK_O    = r_ack;
   assign BUSY_O   = r_pend_v;
   assign o_led    = r_led;
   assign o_bitidx = r_idx;

endmodule

// File: tb/tb_prewish5k_mask_responder.sv
// Bench for prewish5k_mask_responder with 16-cycle bits: a timeline model checked every
// cycle, a constant vector table for IDLE playback, and directed boundary/reset sequences.
module tb_prewish5k_mask_responder;

   localparam int MCB     = 4;
   localparam int BIT_CYC = 16;
   localparam int PAT_CYC = 128;

   logic       i_clk = 1'b0;
   logic       RST_I;
   logic       STB_I;
   logic [7:0] DAT_I;
   logic       ACK_O;
   logic       BUSY_O;
   logic       o_led;
   logic [2:0] o_bitidx;

   int checks = 0;
   int errors = 0;
   int n      = 0;

   // Timeline model: which mask plays, when its first pattern started, what waits.
   bit         m_run;
   logic [7:0] m_mask;
   logic [7:0] m_pend[$];
   int         m_start;
   bit         m_ack;
   bit         e_led;
   bit         e_busy;
   int         e_idx;

   typedef struct {
      int         off;
      logic       led;
      logic [2:0] idx;
      logic       ack;
      logic       busy;
   } vec_t;

   vec_t tbl[12];

   prewish5k_mask_responder #(
      .MASK_CLK_BITS(MCB),
      .MASK_W(8)
   ) dut (
      .i_clk    (i_clk),
      .RST_I    (RST_I),
      .STB_I    (STB_I),
      .DAT_I    (DAT_I),
      .ACK_O    (ACK_O),
      .BUSY_O   (BUSY_O),
      .o_led    (o_led),
      .o_bitidx (o_bitidx)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      bit boundary, free, acc;
      int el, pos;
      if (!RST_I) begin
         m_run = 1'b0;
         m_mask = 8'h00;
         m_pend.delete();
         m_ack = 1'b0;
      end else begin
         boundary = m_run && (((n - m_start) % PAT_CYC) == PAT_CYC - 1);
         free = !m_run || (m_pend.size() == 0) || boundary;
         acc = (STB_I === 1'b1) && !m_ack && free;
         if (boundary && m_pend.size() > 0) m_mask = m_pend.pop_front();
         if (acc) begin
            if (!m_run) begin
               m_run = 1'b1;
               m_mask = DAT_I;
               m_start = n + 1;
            end else begin
               m_pend.push_back(DAT_I);
            end
         end
         m_ack = acc;
      end
      if (m_run) begin
         el = (n + 1 - m_start) % PAT_CYC;
         pos = 7 - el / BIT_CYC;
         e_led = m_mask[pos];
         e_idx = pos;
      end else begin
         e_led = 1'b0;
         e_idx = 0;
      end
      e_busy = (m_pend.size() != 0);
   endtask

   task automatic step();
      logic [2:0] ei;
      model_step();
      @(posedge i_clk);
      #1;
      n++;
      ei = 3'(e_idx);
      check($sformatf("model c%0d {led,ack,busy,idx}", n),
            {26'd0, o_led, ACK_O, BUSY_O, o_bitidx},
            {26'd0, e_led, m_ack, e_busy, ei});
   endtask

   task automatic step_to(input int target);
      while (n < target) step();
   endtask

   task automatic do_reset(input int cycles);
      RST_I = 1'b0;
      STB_I = 1'b0;
      DAT_I = 8'h00;
      repeat (cycles) step();
      RST_I = 1'b1;
   endtask

   task automatic write(input logic [7:0] d, input int max, output int ack_n);
      STB_I = 1'b1;
      DAT_I = d;
      ack_n = -1;
      for (int i = 0; i < max; i++) begin
         step();
         if (ACK_O === 1'b1) begin
            ack_n = n;
            break;
         end
      end
      STB_I = 1'b0;
      checks++;
      if (ack_n < 0) begin
         errors++;
         $display("FAIL ack_timeout: no ACK_O for 0x%02h within %0d cycles", d, max);
      end
   endtask

   initial begin
      int c, a, a2, a3, r;

      tbl[0]  = '{1,   1'b1, 3'd7, 1'b1, 1'b0};
      tbl[1]  = '{2,   1'b1, 3'd7, 1'b0, 1'b0};
      tbl[2]  = '{16,  1'b1, 3'd7, 1'b0, 1'b0};
      tbl[3]  = '{17,  1'b0, 3'd6, 1'b0, 1'b0};
      tbl[4]  = '{32,  1'b0, 3'd6, 1'b0, 1'b0};
      tbl[5]  = '{33,  1'b1, 3'd5, 1'b0, 1'b0};
      tbl[6]  = '{48,  1'b1, 3'd5, 1'b0, 1'b0};
      tbl[7]  = '{49,  1'b0, 3'd4, 1'b0, 1'b0};
      tbl[8]  = '{128, 1'b0, 3'd0, 1'b0, 1'b0};
      tbl[9]  = '{129, 1'b1, 3'd7, 1'b0, 1'b0};
      tbl[10] = '{145, 1'b0, 3'd6, 1'b0, 1'b0};
      tbl[11] = '{161, 1'b1, 3'd5, 1'b0, 1'b0};

      RST_I = 1'b0;
      STB_I = 1'b0;
      DAT_I = 8'h00;

      // Reset and quiet idle
      do_reset(2);
      check("reset led", {31'd0, o_led}, 0);
      check("reset ack", {31'd0, ACK_O}, 0);
      check("reset busy", {31'd0, BUSY_O}, 0);
      check("reset bitidx", {29'd0, o_bitidx}, 0);
      for (int i = 0; i < 300; i++) begin
         step();
         check("idle quiet {led,ack,busy}", {29'd0, o_led, ACK_O, BUSY_O}, 0);
      end

      // IDLE accept of 0xA0 against a constant timeline table
      do_reset(2);
      c = n;
      STB_I = 1'b1;
      DAT_I = 8'hA0;
      step();
      STB_I = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step_to(c + tbl[i].off);
         check($sformatf("tbl[%0d] led", i), {31'd0, o_led}, {31'd0, tbl[i].led});
         check($sformatf("tbl[%0d] idx", i), {29'd0, o_bitidx}, {29'd0, tbl[i].idx});
         check($sformatf("tbl[%0d] ack", i), {31'd0, ACK_O}, {31'd0, tbl[i].ack});
         check($sformatf("tbl[%0d] busy", i), {31'd0, BUSY_O}, {31'd0, tbl[i].busy});
      end

      // Pending mask during playback swaps in at the boundary
      do_reset(2);
      write(8'hA0, 4, a);
      c = a - 1;
      step_to(c + 41);
      write(8'h33, 4, a2);
      check("pend ack cycle", a2, c + 42);
      check("pend busy", {31'd0, BUSY_O}, 1);
      step_to(c + 128);
      check("pre-boundary busy", {31'd0, BUSY_O}, 1);
      check("pre-boundary idx", {29'd0, o_bitidx}, 0);
      step();
      check("post-boundary busy", {31'd0, BUSY_O}, 0);
      check("post-boundary idx", {29'd0, o_bitidx}, 7);
      check("post-boundary led", {31'd0, o_led}, 0);
      step_to(c + 161);
      check("0x33 bit5 led", {31'd0, o_led}, 1);

      // Strobe waiting on a full buffer is acked the cycle after the boundary tick
      do_reset(2);
      write(8'h55, 4, a);
      c = a - 1;
      step_to(c + 30);
      write(8'h33, 4, a2);
      write(8'hF0, 200, a3);
      check("wait ack cycle", a3, c + 129);
      check("wait busy stays", {31'd0, BUSY_O}, 1);
      check("wait 0x33 first led", {31'd0, o_led}, 0);
      step_to(c + 257);
      check("0xF0 start led", {31'd0, o_led}, 1);
      check("0xF0 start busy", {31'd0, BUSY_O}, 0);
      step_to(c + 320);
      check("0xF0 bit4 led", {31'd0, o_led}, 1);
      step();
      check("0xF0 bit3 led", {31'd0, o_led}, 0);

      // Strobe exactly on the boundary tick with an empty buffer goes to pending
      do_reset(2);
      write(8'h0F, 4, a);
      c = a - 1;
      step_to(c + 128);
      write(8'h81, 4, a2);
      check("edge ack cycle", a2, c + 129);
      check("edge busy", {31'd0, BUSY_O}, 1);
      check("edge old mask led", {31'd0, o_led}, 0);
      step_to(c + 193);
      check("old mask repeats led", {31'd0, o_led}, 1);
      step_to(c + 257);
      check("0x81 start led", {31'd0, o_led}, 1);
      check("0x81 start busy", {31'd0, BUSY_O}, 0);
      step_to(c + 273);
      check("0x81 bit6 led", {31'd0, o_led}, 0);

      // Strobe still high during its own ACK cycle is not taken twice
      do_reset(2);
      STB_I = 1'b1;
      DAT_I = 8'h3C;
      step();
      step();
      check("held-through-ack ack", {31'd0, ACK_O}, 0);
      check("held-through-ack busy", {31'd0, BUSY_O}, 0);
      STB_I = 1'b0;
      step();

      // Reset mid-pattern with a full buffer and a waiting strobe
      do_reset(2);
      write(8'hA0, 4, a);
      c = a - 1;
      step_to(c + 20);
      write(8'h33, 4, a2);
      STB_I = 1'b1;
      DAT_I = 8'hC3;
      repeat (10) step();
      check("waiting ack", {31'd0, ACK_O}, 0);
      check("waiting busy", {31'd0, BUSY_O}, 1);
      RST_I = 1'b0;
      step();
      check("mid reset outputs", {26'd0, o_led, ACK_O, BUSY_O, o_bitidx}, 0);
      RST_I = 1'b1;
      step();
      check("after release ack", {31'd0, ACK_O}, 1);
      check("after release led", {31'd0, o_led}, 1);
      check("after release idx", {29'd0, o_bitidx}, 7);
      check("after release busy", {31'd0, BUSY_O}, 0);
      STB_I = 1'b0;
      r = n;
      step_to(r + 17);
      check("0xC3 bit6 led", {31'd0, o_led}, 1);
      step_to(r + 33);
      check("0xC3 bit5 led", {31'd0, o_led}, 0);

      // Randomised traffic against the timeline model
      do_reset(2);
      for (int i = 0; i < 4000; i++) begin
         if (ACK_O === 1'b1) begin
            STB_I = 1'b0;
         end else if (!STB_I && $urandom_range(0, 15) == 0) begin
            STB_I = 1'b1;
            DAT_I = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         end
         RST_I = ($urandom_range(0, 999) != 0);
         step();
      end
      RST_I = 1'b1;
      STB_I = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
